arcade_input_ctrl: RTL and testbench

Player input conditioning stage for the 1942 core. It sits between `hps_io` and `jt1942_game`. It decodes PS/2 key events and merges them with both MiSTer joysticks. It generates the pause toggle, the frame-timed coin pulse and the optional autofire, and it drives the game's active-low joystick, start, coin, pause and test inputs.

---
 rtl/arcade_input_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: player input conditioning for the 1942 core.
// Decodes PS/2 key events, merges them with both MiSTer joysticks, and produces
// the pause toggle, the frame-timed coin pulse and the optional autofire.
// Every output is active-low and registered.
//
// Optional feature macro: AUTOFIRE_EN (per-player fire1 square wave driven by
// key 1A / joy bit 10, AF_FRAMES ticks on, AF_FRAMES ticks off).
//
// Parameters:
//   COIN_FRAMES  frames the coin output stays asserted per press (1..15)
//   AF_FRAMES    autofire half-period in frames (1..15), AUTOFIRE_EN only
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   LVBL                    vertical blank (active-low); its falling edge is the frame tick
//   ps2_key[10:0]           {toggle, pressed, extended, scan code}
//   joy_0, joy_1[15:0]      MiSTer joysticks
//   pause_clr               synchronous pause clear
//   joystick1/2[5:0]        active-low {fire2, fire1, up, down, left, right}
//   start_button[1:0]       active-low {start2, start1}
//   coin_input[1:0]         active-low {1, coin1}
//   dip_pause               0 = paused
//   dip_test                0 = test held
module arcade_input_ctrl #(
  parameter int unsigned COIN_FRAMES = 4,
  parameter int unsigned AF_FRAMES   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LVBL,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        pause_clr,
  output logic [5:0]  joystick1,
  output logic [5:0]  joystick2,
  output logic [1:0]  start_button,
  output logic [1:0]  coin_input,
  output logic        dip_pause,
  output logic        dip_test
);

  // Key flag indices
  localparam int KUp    = 0;
  localparam int KDown  = 1;
  localparam int KLeft  = 2;
  localparam int KRight = 3;
  localparam int KStart1 = 4;
  localparam int KStart2 = 5;
  localparam int KCoin  = 6;
  localparam int KPause = 7;
  localparam int KTest  = 8;
  localparam int KFire1 = 9;
  localparam int KFire2 = 10;

  logic        ps2_tog_q;
  logic [10:0] keys_q, keys_d;
  logic        lvbl_q, lvbl_d1_q;
  logic        frame_tick;
  logic        coin_prev_q, pause_prev_q;
  logic [3:0]  coin_cnt_q, coin_cnt_d;
  logic        pause_q, pause_d;

  logic [5:0]  p1, p2;
  logic [1:0]  start_m;
  logic        coin_m, pause_m;
  logic        ps2_evt;

  assign ps2_evt    = ps2_key[10] ^ ps2_tog_q;
  assign frame_tick = lvbl_d1_q & ~lvbl_q;

  // PS/2 decode: the scan code present with the toggle selects the flag.
  always_comb begin
    keys_d = keys_q;
    if (ps2_evt) begin
      case (ps2_key[7:0])
        8'h75:        keys_d[KUp]     = ps2_key[9];
        8'h72:        keys_d[KDown]   = ps2_key[9];
        8'h6B:        keys_d[KLeft]   = ps2_key[9];
        8'h74:        keys_d[KRight]  = ps2_key[9];
        8'h05:        keys_d[KStart1] = ps2_key[9];
        8'h06:        keys_d[KStart2] = ps2_key[9];
        8'h04:        keys_d[KCoin]   = ps2_key[9];
        8'h0C:        keys_d[KPause]  = ps2_key[9];
        8'h03:        keys_d[KTest]   = ps2_key[9];
        8'h14, 8'h11: keys_d[KFire1]  = ps2_key[9];
        8'h29:        keys_d[KFire2]  = ps2_key[9];
        default: ;
      endcase
    end
  end

`ifdef AUTOFIRE_EN
  logic            af_key_q, af_key_d;
  logic [1:0]      af_held;
  logic [1:0]      af_off_q, af_off_d;
  logic [1:0][3:0] af_cnt_q, af_cnt_d;
  logic [1:0]      af_wave;

  always_comb begin
    af_key_d = af_key_q;
    if (ps2_evt && ps2_key[7:0] == 8'h1A) af_key_d = ps2_key[9];
  end

  assign af_held = {joy_1[10], af_key_q | joy_0[10]};

  // Phase counts ticks within the current half-period; the wave starts in the
  // asserted half on every press so the first shot is immediate.
  always_comb begin
    af_cnt_d = af_cnt_q;
    af_off_d = af_off_q;
    for (int p = 0; p < 2; p++) begin
      if (!af_held[p]) begin
        af_cnt_d[p] = 4'd0;
        af_off_d[p] = 1'b0;
      end else if (frame_tick) begin
        if (af_cnt_q[p] == 4'(AF_FRAMES - 1)) begin
          af_cnt_d[p] = 4'd0;
          af_off_d[p] = ~af_off_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + 4'd1;
        end
      end
    end
  end

  assign af_wave = af_held & ~af_off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_key_q <= 1'b0;
      af_cnt_q <= '0;
      af_off_q <= '0;
    end else begin
      af_key_q <= af_key_d;
      af_cnt_q <= af_cnt_d;
      af_off_q <= af_off_d;
    end
  end
`else
  logic [1:0] af_wave;
  assign af_wave = 2'b00;
  logic unused_af;
  assign unused_af = ^{32'(AF_FRAMES), joy_0[10], joy_1[10]};
`endif

  logic unused_in;
  assign unused_in = ^{ps2_key[8], joy_0[15:11], joy_1[15:11]};

  // Merge keys and joysticks (active-high here, inverted at the outputs).
  always_comb begin
    p1 = {keys_q[KFire2] | joy_0[5],
          keys_q[KFire1] | joy_0[4] | af_wave[0],
          keys_q[KUp]    | joy_0[3],
          keys_q[KDown]  | joy_0[2],
          keys_q[KLeft]  | joy_0[1],
          keys_q[KRight] | joy_0[0]};
    p2 = {joy_1[5], joy_1[4] | af_wave[1], joy_1[3:0]};
    start_m = {keys_q[KStart2] | joy_0[7] | joy_1[7],
               keys_q[KStart1] | joy_0[6] | joy_1[6]};
    coin_m  = keys_q[KCoin]  | joy_0[8] | joy_1[8];
    pause_m = keys_q[KPause] | joy_0[9] | joy_1[9];
  end

  // Coin: load on a rising edge only when idle; load beats a same-cycle tick.
  always_comb begin
    coin_cnt_d = coin_cnt_q;
    if (coin_m && !coin_prev_q && coin_cnt_q == 4'd0) begin
      coin_cnt_d = 4'(COIN_FRAMES);
    end else if (frame_tick && coin_cnt_q != 4'd0) begin
      coin_cnt_d = coin_cnt_q - 4'd1;
    end
  end

  always_comb begin
    pause_d = pause_q;
    if (pause_clr) begin
      pause_d = 1'b0;
    end else if (pause_m && !pause_prev_q) begin
      pause_d = ~pause_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_tog_q    <= 1'b0;
      keys_q       <= '0;
      lvbl_q       <= 1'b0;
      lvbl_d1_q    <= 1'b0;
      coin_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      coin_cnt_q   <= 4'd0;
      pause_q      <= 1'b0;
      joystick1    <= 6'h3F;
      joystick2    <= 6'h3F;
      start_button <= 2'b11;
      coin_input   <= 2'b11;
      dip_pause    <= 1'b1;
      dip_test     <= 1'b1;
    end else begin
      ps2_tog_q    <= ps2_key[10];
      keys_q       <= keys_d;
      lvbl_q       <= LVBL;
      lvbl_d1_q    <= lvbl_q;
      coin_prev_q  <= coin_m;
      pause_prev_q <= pause_m;
      coin_cnt_q   <= coin_cnt_d;
      pause_q      <= pause_d;
      joystick1    <= ~p1;
      joystick2    <= ~p2;
      start_button <= ~start_m;
      coin_input   <= {1'b1, coin_cnt_d == 4'd0};
      dip_pause    <= ~pause_d;
      dip_test     <= ~keys_q[KTest];
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

  localparam int unsigned CoinFrames = 4;
  localparam int unsigned AfFrames   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        LVBL;
  logic [10:0] ps2_key;
  logic [15:0] joy_0, joy_1;
  logic        pause_clr;
  logic [5:0]  joystick1, joystick2;
  logic [1:0]  start_button, coin_input;
  logic        dip_pause, dip_test;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  arcade_input_ctrl #(
    .COIN_FRAMES(CoinFrames),
    .AF_FRAMES  (AfFrames)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .LVBL        (LVBL),
    .ps2_key     (ps2_key),
    .joy_0       (joy_0),
    .joy_1       (joy_1),
    .pause_clr   (pause_clr),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .start_button(start_button),
    .coin_input  (coin_input),
    .dip_pause   (dip_pause),
    .dip_test    (dip_test)
  );

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    logic [5:0]  e1;
    logic [5:0]  e2;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One frame: LVBL low then high; the tick lands well inside the low phase.
  task automatic frame();
    LVBL = 1'b0;
    repeat (4) @(negedge clk);
    LVBL = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic ps2_send(input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 6'h3F, 6'h3F, 2'b11};
    vecs[1] = '{16'h0001, 16'h0000, 6'h3E, 6'h3F, 2'b11};
    vecs[2] = '{16'h0030, 16'h0000, 6'h0F, 6'h3F, 2'b11};
    vecs[3] = '{16'h0000, 16'h000C, 6'h3F, 6'h33, 2'b11};
    vecs[4] = '{16'h0040, 16'h0000, 6'h3F, 6'h3F, 2'b10};
    vecs[5] = '{16'h0000, 16'h0080, 6'h3F, 6'h3F, 2'b01};
    vecs[6] = '{16'h0040, 16'h0080, 6'h3F, 6'h3F, 2'b00};
    vecs[7] = '{16'h003F, 16'h0022, 6'h00, 6'h1D, 2'b11};
`ifdef AUTOFIRE_EN
    vecs[8] = '{16'h0400, 16'h0000, 6'h2F, 6'h3F, 2'b11};
`else
    vecs[8] = '{16'h0400, 16'h0000, 6'h3F, 6'h3F, 2'b11};
`endif
    vecs[9] = '{16'h0000, 16'h0000, 6'h3F, 6'h3F, 2'b11};

    rst_n = 1'b0; LVBL = 1'b1; ps2_key = '0; joy_0 = '0; joy_1 = '0; pause_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_joy1", {26'd0, joystick1}, 32'h3F);
    check("rst_joy2", {26'd0, joystick2}, 32'h3F);
    check("rst_start", {30'd0, start_button}, 32'h3);
    check("rst_coin", {30'd0, coin_input}, 32'h3);
    check("rst_pause", {31'd0, dip_pause}, 32'h1);
    check("rst_test", {31'd0, dip_test}, 32'h1);

    // Joystick merge vectors, one clk latency each.
    for (int i = 0; i < 10; i++) begin
      joy_0 = vecs[i].j0;
      joy_1 = vecs[i].j1;
      @(negedge clk);
      check($sformatf("vec%0d_joy1", i), {26'd0, joystick1}, {26'd0, vecs[i].e1});
      check($sformatf("vec%0d_joy2", i), {26'd0, joystick2}, {26'd0, vecs[i].e2});
      check($sformatf("vec%0d_start", i), {30'd0, start_button}, {30'd0, vecs[i].es});
    end

    // PS/2 up key: two clks from toggle to output.
    ps2_send(1'b1, 8'h75);
    @(negedge clk);
    check("ps2_up_1clk", {26'd0, joystick1}, 32'h3F);
    @(negedge clk);
    check("ps2_up_2clk", {26'd0, joystick1}, 32'h37);
    check("ps2_up_joy2", {26'd0, joystick2}, 32'h3F);
    ps2_send(1'b0, 8'h75);
    repeat (2) @(negedge clk);
    check("ps2_up_rel", {26'd0, joystick1}, 32'h3F);
    ps2_send(1'b1, 8'h72);
    repeat (2) @(negedge clk);
    check("ps2_down", {26'd0, joystick1}, 32'h3B);
    ps2_send(1'b1, 8'h55);  // unmapped code leaves flags alone
    repeat (2) @(negedge clk);
    check("ps2_other", {26'd0, joystick1}, 32'h3B);
    ps2_send(1'b0, 8'h72);
    repeat (2) @(negedge clk);
    ps2_send(1'b1, 8'h03);
    repeat (2) @(negedge clk);
    check("ps2_test", {31'd0, dip_test}, 32'h0);
    ps2_send(1'b0, 8'h03);
    repeat (2) @(negedge clk);
    check("ps2_test_rel", {31'd0, dip_test}, 32'h1);

    // Pause toggle and clear.
    joy_0 = 16'h0200; @(negedge clk); joy_0 = '0;
    check("pause_on", {31'd0, dip_pause}, 32'h0);
    @(negedge clk);
    joy_0 = 16'h0200; @(negedge clk); joy_0 = '0;
    check("pause_off", {31'd0, dip_pause}, 32'h1);
    @(negedge clk);
    joy_0 = 16'h0200; pause_clr = 1'b1; @(negedge clk); joy_0 = '0; pause_clr = 1'b0;
    check("pause_clr_wins", {31'd0, dip_pause}, 32'h1);
    @(negedge clk);
    joy_0 = 16'h0200; @(negedge clk); joy_0 = '0;
    check("pause_on2", {31'd0, dip_pause}, 32'h0);
    pause_clr = 1'b1; @(negedge clk); pause_clr = 1'b0;
    check("pause_clr", {31'd0, dip_pause}, 32'h1);

    // Coin held 20 frames: exactly one CoinFrames-tick pulse.
    joy_1 = 16'h0100;
    @(negedge clk);
    check("coin_start", {30'd0, coin_input}, 32'h2);
    for (int f = 1; f <= 20; f++) begin
      frame();
      check($sformatf("coin_f%0d", f), {30'd0, coin_input}, (f < CoinFrames) ? 32'h2 : 32'h3);
    end
    joy_1 = '0;
    frame();
    joy_1 = 16'h0100;
    @(negedge clk);
    check("coin2_start", {30'd0, coin_input}, 32'h2);
    for (int f = 1; f <= CoinFrames; f++) begin
      frame();
      check($sformatf("coin2_f%0d", f), {30'd0, coin_input}, (f < CoinFrames) ? 32'h2 : 32'h3);
    end
    joy_1 = '0;
    frame();

    // Coin edge in the same cycle as a tick: full count, no decrement.
    LVBL = 1'b0;
    @(negedge clk);
    joy_1 = 16'h0100;
    @(negedge clk);
    check("coin_tick_start", {30'd0, coin_input}, 32'h2);
    repeat (2) @(negedge clk);
    LVBL = 1'b1;
    repeat (4) @(negedge clk);
    for (int f = 1; f <= CoinFrames; f++) begin
      frame();
      check($sformatf("coin_tick_f%0d", f), {30'd0, coin_input},
            (f < CoinFrames) ? 32'h2 : 32'h3);
    end
    joy_1 = '0;
    frame();

    // Reset two frames into a pulse clears it asynchronously.
    joy_1 = 16'h0100;
    @(negedge clk);
    frame();
    frame();
    check("coin_pre_rst", {30'd0, coin_input}, 32'h2);
    rst_n = 1'b0;
    #1;
    check("coin_async_rst", {30'd0, coin_input}, 32'h3);
    joy_1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("coin_post_rst", {30'd0, coin_input}, 32'h3);
    frame();
    check("coin_post_rst_f", {30'd0, coin_input}, 32'h3);

    // Autofire on P1 held for 12 frames, sampled before each tick.
    joy_0 = 16'h0400;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
`ifdef AUTOFIRE_EN
      check($sformatf("af_f%0d", i), {31'd0, joystick1[4]}, ((i / AfFrames) % 2 == 1) ? 32'h1 : 32'h0);
`else
      check($sformatf("af_f%0d", i), {31'd0, joystick1[4]}, 32'h1);
`endif
      frame();
    end
    joy_0 = '0;
    @(negedge clk);
    check("af_release", {31'd0, joystick1[4]}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
